// File: rtl/fifo_read_conn_fwft_pkg.sv
// ============================================================================
// Module   : fifo_read_conn_fwft_pkg
// Brief    : Shared helpers for the FIFO connector family (width math, depth).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_read_conn_fwft_pkg;

    // Ceiling log2; constant-evaluable so it can size ports and localparams.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int buf_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic bit latency_legal(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_conn_skid_buf.sv
// ============================================================================
// Module   : fifo_conn_skid_buf
// Brief    : Small circular prefetch buffer with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_conn_skid_buf
    import fifo_read_conn_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    localparam int CNT_W     = clog2(DEPTH + 1),
    localparam int PTR_W     = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]      count
);

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_pop;

    // Depth is generally not a power of two, so the wrap is explicit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    assign w_pop = rd_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            assert (!(wr_valid && (r_count == c_full_cnt)));
            if (wr_valid) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({wr_valid, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_read_conn_fwft.sv
// ============================================================================
// Module   : fifo_read_conn_fwft
// Brief    : Standard-mode FIFO read port to first-word-fall-through consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_conn_fwft
    import fifo_read_conn_fwft_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    localparam int BUF_DEPTH   = buf_depth(READ_LATENCY),
    localparam int CNT_W       = clog2(BUF_DEPTH + 1)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  empty,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] din_dst,
    output logic                  empty_n,
    input  logic                  rd_en_dst,
    output logic [CNT_W-1:0]      data_count
);

    localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(BUF_DEPTH);

    generate
        if (!latency_legal(READ_LATENCY)) begin : g_latency_check
            $error("fifo_read_conn_fwft: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [READ_LATENCY-1:0] r_inflight;
    logic [CNT_W-1:0]        w_inflight_cnt;
    logic [CNT_W:0]          w_credit_used;
    logic                    w_arrive;
    logic                    w_pop;

    generate
        if (READ_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    r_inflight <= '0;
                end else begin
                    r_inflight <= rd_en;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    r_inflight <= '0;
                end else begin
                    r_inflight <= {r_inflight[READ_LATENCY-2:0], rd_en};
                end
            end
        end
    endgenerate

    assign w_arrive = r_inflight[READ_LATENCY-1];

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + CNT_W'(r_inflight[i]);
        end
    end

    // Credit counts every word already held or still coming back from the FIFO,
    // so the request never depends on the consumer's pop in the same cycle.
    assign w_credit_used = {1'b0, data_count} + {1'b0, w_inflight_cnt};
    assign rd_en         = !ap_rst && !empty && (w_credit_used < c_depth);

    assign empty_n = (data_count != '0);
    assign w_pop   = empty_n && rd_en_dst;

    fifo_conn_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid_buf (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .wr_valid (w_arrive),
        .wr_data  (dout),
        .rd_pop   (w_pop),
        .rd_data  (din_dst),
        .count    (data_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_conn_fwft.sv
// ============================================================================
// Module   : tb_fifo_read_conn_fwft
// Brief    : Directed bench for the FWFT read connector at latency 1 and 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_read_conn_fwft;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ap_rst = 1'b1;

    logic [DW-1:0] dout1 = '0;
    logic [DW-1:0] din_dst1;
    logic          empty1 = 1'b1;
    logic          rd_en1;
    logic          empty_n1;
    logic          rd_en_dst1 = 1'b0;
    logic [1:0]    data_count1;

    logic [DW-1:0] dout2 = '0;
    logic [DW-1:0] dout2_p = '0;
    logic [DW-1:0] din_dst2;
    logic          empty2 = 1'b1;
    logic          rd_en2;
    logic          empty_n2;
    logic          rd_en_dst2 = 1'b0;
    logic [2:0]    data_count2;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend1[$];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_read_conn_fwft #(.DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
        .ap_clk     (clk),
        .ap_rst     (ap_rst),
        .dout       (dout1),
        .empty      (empty1),
        .rd_en      (rd_en1),
        .din_dst    (din_dst1),
        .empty_n    (empty_n1),
        .rd_en_dst  (rd_en_dst1),
        .data_count (data_count1)
    );

    fifo_read_conn_fwft #(.DATA_WIDTH(DW), .READ_LATENCY(2)) dut2 (
        .ap_clk     (clk),
        .ap_rst     (ap_rst),
        .dout       (dout2),
        .empty      (empty2),
        .rd_en      (rd_en2),
        .din_dst    (din_dst2),
        .empty_n    (empty_n2),
        .rd_en_dst  (rd_en_dst2),
        .data_count (data_count2)
    );

    // Standard-mode source FIFOs: registered empty, data READ_LATENCY after rd_en.
    always @(posedge clk) begin
        if (ap_rst) begin
            q1.delete();
            empty1 <= 1'b1;
            dout1  <= '0;
        end else begin
            if (rd_en1 && !empty1) dout1 <= q1.pop_front();
            empty1 <= (q1.size() == 0);
        end
    end

    always @(posedge clk) begin
        if (ap_rst) begin
            q2.delete();
            empty2  <= 1'b1;
            dout2_p <= '0;
            dout2   <= '0;
        end else begin
            if (rd_en2 && !empty2) dout2_p <= q2.pop_front();
            dout2  <= dout2_p;
            empty2 <= (q2.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs the latency-1 DUT until n words are consumed; rnd randomises both
    // FIFO refill and consumer readiness.
    task automatic run1(input int n, input int budget, input bit rnd);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (pend1.size() != 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                logic [31:0] w;
                w = pend1.pop_front();
                q1.push_back(w);
                exp_q.push_back(w);
            end
            rd_en_dst1 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (empty_n1 && rd_en_dst1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_word: got 0x%0h expected no word", din_dst1);
                end else begin
                    check("order", din_dst1, exp_q.pop_front());
                end
                got++;
            end
            @(posedge clk); #1;
        end
        rd_en_dst1 = 1'b0;
        check("words_delivered", got, n);
    endtask

    typedef struct {
        logic        rd_en_dst;
        logic        exp_rd_en;
        logic        exp_empty_n;
        logic        chk_din;
        logic [31:0] exp_din;
        logic [1:0]  exp_count;
    } vec_t;

    vec_t vecs[7];
    int   got2;
    int   first2;
    bit   seen;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 2'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2'd1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 2'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0};

        ap_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 ap_rst = 1'b0;

        // Idle with empty source FIFOs
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_rd_en", rd_en1, 1'b0);
            check("idle_empty_n", empty_n1, 1'b0);
            check("idle_count", data_count1, 2'd0);
            check("idle_din", din_dst1, 32'h0);
            check("idle_rd_en2", rd_en2, 1'b0);
            @(posedge clk); #1;
        end

        // Three-word burst, latency 1, consumer always ready
        q1.push_back(32'h11);
        q1.push_back(32'h22);
        q1.push_back(32'h33);
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            rd_en_dst1 = vecs[k].rd_en_dst;
            @(negedge clk);
            check($sformatf("burst_rd_en[%0d]", k), rd_en1, vecs[k].exp_rd_en);
            check($sformatf("burst_empty_n[%0d]", k), empty_n1, vecs[k].exp_empty_n);
            check($sformatf("burst_count[%0d]", k), data_count1, vecs[k].exp_count);
            if (vecs[k].chk_din) check($sformatf("burst_din[%0d]", k), din_dst1, vecs[k].exp_din);
            @(posedge clk); #1;
        end
        rd_en_dst1 = 1'b0;

        // Latency 2, 100-word stream, consumer always ready
        for (int i = 0; i < 100; i++) q2.push_back(i);
        rd_en_dst2 = 1'b1;
        got2   = 0;
        first2 = -1;
        @(posedge clk); #1;
        for (int c = 0; c < 130 && got2 < 100; c++) begin
            @(negedge clk);
            if (c < 100) check("l2_rd_en", rd_en2, 1'b1);
            if (empty_n2) begin
                if (first2 < 0) first2 = c;
                check("l2_data", din_dst2, got2);
                check("l2_no_bubble", c, 3 + got2);
                got2++;
            end
            @(posedge clk); #1;
        end
        rd_en_dst2 = 1'b0;
        check("l2_first_cycle", first2, 3);
        check("l2_words", got2, 100);

        // Consumer stalled: buffer fills to its depth and stops requesting
        rd_en_dst1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            q1.push_back(i);
            exp_q.push_back(i);
        end
        repeat (8) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_count", data_count1, 2'd3);
        check("stall_rd_en", rd_en1, 1'b0);
        check("stall_empty_n", empty_n1, 1'b1);
        check("stall_head", din_dst1, 32'h0);
        @(posedge clk); #1;
        run1(10, 80, 1'b0);
        check("stall_drained", exp_q.size(), 0);

        // Sparse refill with consumer asserting rd_en_dst while empty
        for (int i = 0; i < 40; i++) pend1.push_back(32'h1000 + i);
        run1(40, 800, 1'b1);
        check("rand_no_loss", exp_q.size(), 0);
        @(negedge clk);
        check("rand_final_count", data_count1, 2'd0);
        @(posedge clk); #1;

        // Reset while two words held and one in flight
        q1.push_back(32'h55);
        q1.push_back(32'h66);
        q1.push_back(32'h77);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (data_count1 == 2'd2) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_setup_reached", seen, 1'b1);
        ap_rst = 1'b1;
        @(posedge clk); #1;
        ap_rst = 1'b0;
        @(negedge clk);
        check("rst_empty_n", empty_n1, 1'b0);
        check("rst_count", data_count1, 2'd0);
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            check("rst_stays_empty", empty_n1, 1'b0);
            @(posedge clk); #1;
        end
        exp_q.delete();
        pend1.push_back(32'hA0);
        pend1.push_back(32'hA1);
        pend1.push_back(32'hA2);
        run1(3, 40, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_resume_empty", empty_n1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
